// File: rtl/operand_mult_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_mult_sequencer_if : switch/button/multiplier bundle (rev 1.0)
// ---------------------------------------------------------------------------
interface operand_mult_sequencer_if;
  logic [7:0]  sw_a;
  logic [7:0]  sw_b;
  logic        btn_load;
  logic        mult_done;
  logic [15:0] mult_result;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        mult_start;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        err;

  modport master (
    input  sw_a, sw_b, btn_load, mult_done, mult_result,
    output op_a, op_b, mult_start, result, result_valid, busy, err
  );

  modport slave (
    output sw_a, sw_b, btn_load, mult_done, mult_result,
    input  op_a, op_b, mult_start, result, result_valid, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/operand_mult_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_mult_sequencer : one debounced press -> one multiply (rev 1.0)
// ---------------------------------------------------------------------------
module operand_mult_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input wire logic                  clk,
  input wire logic                  rst_n,
  operand_mult_sequencer_if.master  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb;
  logic              r_deb_d;
  logic [CNT_W-1:0]  r_deb_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [7:0]        r_op_a;
  logic [7:0]        r_op_b;
  logic [15:0]       r_result;
  logic              r_result_valid;
  logic              r_err;
  logic              w_load_evt;
  logic              w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.btn_load;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 != r_deb) begin
        if (r_deb_cnt == c_DEB_LAST) begin
          r_deb     <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // Only the debounced press edge launches work; release is silent.
  assign w_load_evt = r_deb & ~r_deb_d;
  assign w_accept   = w_load_evt &&
                      (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_accept) w_state_nxt = S_START;
      S_START:               w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mult_done)              w_state_nxt = S_DONE;
        else if (r_timer == c_TMR_LAST) w_state_nxt = S_ERR;
      end
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_timer        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_accept) begin
            r_op_a         <= bus.sw_a;
            r_op_b         <= bus.sw_b;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
          end
        end
        S_START: r_timer <= '0;
        S_WAIT: begin
          // A done arriving on the last timeout cycle still counts.
          if (bus.mult_done) begin
            r_result       <= bus.mult_result;
            r_result_valid <= 1'b1;
          end else if (r_timer == c_TMR_LAST) begin
            r_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_a         = r_op_a;
  assign bus.op_b         = r_op_b;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.err          = r_err;
  assign bus.mult_start   = (r_state == S_START);
  assign bus.busy         = (r_state == S_START) || (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_operand_mult_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_operand_mult_sequencer : directed self-checking bench (rev 1.0)
// ---------------------------------------------------------------------------
module tb_operand_mult_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   n_start;

  operand_mult_sequencer_if u_if ();

  operand_mult_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (u_if.mult_start === 1'b1) n_start <= n_start + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".op_a"},   32'(u_if.op_a),         32'h0);
    chk({tag, ".op_b"},   32'(u_if.op_b),         32'h0);
    chk({tag, ".result"}, 32'(u_if.result),       32'h0);
    chk({tag, ".valid"},  32'(u_if.result_valid), 32'h0);
    chk({tag, ".busy"},   32'(u_if.busy),         32'h0);
    chk({tag, ".err"},    32'(u_if.err),          32'h0);
    chk({tag, ".start"},  32'(u_if.mult_start),   32'h0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_start = 0;
    rst_n = 1'b1;
    u_if.sw_a = 8'h00; u_if.sw_b = 8'h00; u_if.btn_load = 1'b0;
    u_if.mult_done = 1'b0; u_if.mult_result = 16'h0000;
    #2 rst_n = 1'b0;
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Nominal: press held 10 cycles, product returned 3 cycles after start
    u_if.sw_a = 8'h0C; u_if.sw_b = 8'h05; u_if.btn_load = 1'b1;
    tick(6);
    chk("nom.no_early_start", 32'(u_if.mult_start), 32'h0);
    tick(1);
    chk("nom.start",  32'(u_if.mult_start), 32'h1);
    chk("nom.op_a",   32'(u_if.op_a),       32'h0C);
    chk("nom.op_b",   32'(u_if.op_b),       32'h05);
    chk("nom.busy",   32'(u_if.busy),       32'h1);
    tick(3);
    chk("nom.start_once", 32'(u_if.mult_start),   32'h0);
    chk("nom.valid_pre",  32'(u_if.result_valid), 32'h0);
    u_if.btn_load = 1'b0;
    u_if.mult_done = 1'b1; u_if.mult_result = 16'h003C;
    tick(1);
    u_if.mult_done = 1'b0; u_if.mult_result = 16'hBEEF;
    chk("nom.result", 32'(u_if.result),       32'h003C);
    chk("nom.valid",  32'(u_if.result_valid), 32'h1);
    chk("nom.busy0",  32'(u_if.busy),         32'h0);
    tick(12);
    chk("nom.n_start", 32'(n_start),     32'd1);
    chk("nom.hold",    32'(u_if.result), 32'h003C);

    // Bounce: 2-cycle toggles never survive the 4-cycle filter
    for (int i = 0; i < 6; i++) begin
      u_if.btn_load = (i % 2 == 0);
      tick(2);
    end
    u_if.btn_load = 1'b0;
    tick(10);
    chk("bounce.n_start", 32'(n_start),           32'd1);
    chk("bounce.result",  32'(u_if.result),       32'h003C);
    chk("bounce.valid",   32'(u_if.result_valid), 32'h1);
    chk("bounce.op_a",    32'(u_if.op_a),         32'h0C);

    // Second press and switch change while WAIT is in progress
    u_if.sw_b = 8'h06; u_if.btn_load = 1'b1;
    tick(4);
    u_if.btn_load = 1'b0;
    tick(3);
    chk("wp.start", 32'(u_if.mult_start), 32'h1);
    chk("wp.op_b",  32'(u_if.op_b),       32'h06);
    tick(1);
    u_if.btn_load = 1'b1; u_if.sw_a = 8'hFF;
    tick(7);
    chk("wp.busy",    32'(u_if.busy), 32'h1);
    chk("wp.dropped", 32'(n_start),   32'd2);
    // Done on the final timeout cycle must win over the timeout
    u_if.mult_done = 1'b1; u_if.mult_result = 16'h0048;
    tick(1);
    u_if.mult_done = 1'b0; u_if.mult_result = 16'h0000;
    chk("wp.result", 32'(u_if.result),       32'h0048);
    chk("wp.valid",  32'(u_if.result_valid), 32'h1);
    chk("wp.err",    32'(u_if.err),          32'h0);
    chk("wp.op_a",   32'(u_if.op_a),         32'h0C);
    u_if.btn_load = 1'b0;
    tick(12);
    chk("wp.release_silent", 32'(n_start), 32'd2);

    // Press from DONE captures FF; then the multiplier stays silent
    u_if.btn_load = 1'b1;
    tick(7);
    chk("dn.start",  32'(u_if.mult_start),   32'h1);
    chk("dn.op_a",   32'(u_if.op_a),         32'h0FF);
    chk("dn.valid",  32'(u_if.result_valid), 32'h0);
    chk("dn.result", 32'(u_if.result),       32'h0048);
    tick(1);
    u_if.btn_load = 1'b0;
    tick(7);
    chk("to.busy_last", 32'(u_if.busy), 32'h1);
    chk("to.err_pre",   32'(u_if.err),  32'h0);
    tick(1);
    chk("to.err",   32'(u_if.err),          32'h1);
    chk("to.busy",  32'(u_if.busy),         32'h0);
    chk("to.valid", 32'(u_if.result_valid), 32'h0);

    // Next press clears err and restarts
    tick(10);
    u_if.btn_load = 1'b1;
    tick(7);
    chk("rs.start", 32'(u_if.mult_start), 32'h1);
    chk("rs.err",   32'(u_if.err),        32'h0);
    tick(2);
    chk("rs.busy",  32'(u_if.busy),       32'h1);

    // Asynchronous reset mid-WAIT, mid-cycle
    u_if.btn_load = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_all_zero("areset");
    tick(2);
    rst_n = 1'b1;
    u_if.mult_done = 1'b1; u_if.mult_result = 16'h1234;
    tick(1);
    u_if.mult_done = 1'b0; u_if.mult_result = 16'h0000;
    tick(3);
    chk("post.valid",   32'(u_if.result_valid), 32'h0);
    chk("post.result",  32'(u_if.result),       32'h0);
    chk("post.busy",    32'(u_if.busy),         32'h0);
    chk("post.n_start", 32'(n_start),           32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_mult_sequencer.md
Name: operand_mult_sequencer

Overview:
- Sequences one multiply operation per user button press.
- Synchronizes and debounces the raw load button, then snapshots the two 8-bit switch operands from the switch input controller.
- Issues a single-cycle start pulse to the downstream multiplier, waits for its done handshake, and holds the 16-bit product for the display path.
- Flags an error if the multiplier never answers.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before the debounced button level flips (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before error.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_a  input  8  operand A from the switch controller.
- sw_b  input  8  operand B from the switch controller.
- btn_load  input  1  raw, asynchronous, bouncing push-button.
- mult_done  input  1  multiplier completion pulse.
- mult_result  input  16  multiplier product; valid while mult_done=1.
- op_a  output  8  latched operand A to the multiplier.
- op_b  output  8  latched operand B to the multiplier.
- mult_start  output  1  one-cycle start pulse.
- result  output  16  held product.
- result_valid  output  1  result holds a fresh product.
- busy  output  1  operation in flight.
- err  output  1  timeout occurred.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: all cleared (op_a, op_b, result, result_valid, busy, err, mult_start = 0).
  - Internal: state=IDLE, debounce counter=0, debounced level=0, timer=0, synchronizer flops=0.
  - Effect is immediate, including mid-operation. Release is sampled on the next clk rising edge.
- Input conditioning:
  - btn_load passes through a 2-flop synchronizer.
  - Debounce counter increments each cycle the synchronized level differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - load_evt is a one-cycle pulse on the debounced rising edge only; release generates nothing.
- FSM states: IDLE, START, WAIT, DONE, ERR.
  - IDLE/DONE/ERR, on load_evt:
    - op_a<=sw_a, op_b<=sw_b, result_valid<=0, err<=0, next state START.
    - Otherwise hold state.
  - START:
    - mult_start=1 for exactly this cycle, timer<=0.
    - Next state WAIT, unconditionally.
  - WAIT, priority order:
    - mult_done=1: result<=mult_result, result_valid<=1, next state DONE.
    - Else timer==TIMEOUT_CYCLES-1: err<=1, next state ERR.
    - Else timer<=timer+1.
    - If mult_done and timeout coincide, done wins.
- Outputs and timing:
  - busy=1 in START and WAIT; decoded from the state register.
  - mult_start is decoded from the state register (glitch-free, no added latency).
  - Latency: load_evt in cycle t → op_a/op_b valid and mult_start=1 in cycle t+1. mult_done in cycle d → result/result_valid visible in cycle d+1.
- Ignored events:
  - load_evt in START/WAIT is dropped (not queued).
  - mult_done outside WAIT is ignored.
  - sw_a/sw_b changes after capture do not affect op_a/op_b until the next load_evt.
- result is held unchanged in IDLE, DONE and ERR. It is only overwritten by a new product or by reset.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
- Nominal (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8):
  - Stimulus: sw_a=8'h0C, sw_b=8'h05, btn_load held high 10 cycles; model asserts mult_done with 16'h003C three cycles after start.
  - Response: exactly one mult_start pulse; op_a=0C, op_b=05; result=003C; result_valid=1 one cycle after done; busy=0.
- Bounce: btn_load toggling every 2 cycles for 12 cycles, then low → no mult_start, state stays IDLE, outputs unchanged.
- Press and switch change during WAIT:
  - Stimulus: second debounced press plus sw_a changed to 8'hFF while busy=1.
  - Response: no second mult_start; op_a stays 0C; a later press from DONE captures FF and clears result_valid.
- Timeout: mult_done never asserted → err=1 after 8 WAIT cycles, busy=0, result_valid=0; the next press clears err and restarts.
- Reset mid-WAIT, then mult_done pulsed after rst_n release → state IDLE, result_valid stays 0, result stays 16'h0000.
